word_packer: RTL

- Width up-converter sitting directly downstream of the channel FIFO.
- Consumes IN_W-bit words over a valid/ready handshake and packs RATIO consecutive words into one IN_W*RATIO-bit output word for the command/instruction decode stage.
- Supports early termination via in_last_i: a partial word is emitted zero-padded, with a lane-valid mask.
- Single output register stage; sustains one input word per cycle while the consumer keeps up.

---
 rtl/word_packer.sv | 112 +++++++++++
 1 files changed

// File: rtl/word_packer.sv
// Width up-converter: packs RATIO consecutive IN_W-bit words into one output word,
// with early termination on in_last_i. Define WORD_PACKER_MSB_FIRST_EN for MSB-first lane order.
module word_packer #(
    parameter int IN_W  = 32,
    parameter int RATIO = 4
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  en_i,
    input  logic                  in_val_i,
    input  logic [IN_W-1:0]       in_data_i,
    input  logic                  in_last_i,
    output logic                  in_rdy_o,
    output logic                  out_val_o,
    output logic [IN_W*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]      out_keep_o,
    output logic                  out_last_o,
    input  logic                  out_rdy_i
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0] idx_q,  idx_d;
    logic [OUT_W-1:0] acc_q,  acc_d;
    logic             full_q, full_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;

    logic             accept;
    logic             xfer;
    logic             complete;
    logic [RATIO-1:0] lane_hit;
    logic [RATIO-1:0] keep_mask;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] merged_masked;

    // Ready looks only at the output register, never at the input side.
    assign in_rdy_o  = en_i & ~srst_i & (~full_q | out_rdy_i);
    assign out_val_o = en_i & ~srst_i & full_q;

    assign accept   = in_val_i & in_rdy_o;
    assign xfer     = out_val_o & out_rdy_i;
    assign complete = (idx_q == LAST_IDX) | in_last_i;

    // Per-lane steering: POS is the packet position that lands in lane gi.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
`ifdef WORD_PACKER_MSB_FIRST_EN
        localparam int POS = RATIO - 1 - gi;
`else
        localparam int POS = gi;
`endif
        assign lane_hit[gi]  = (idx_q == IDX_W'(POS));
        assign keep_mask[gi] = (IDX_W'(POS) <= idx_q);
        assign merged[gi*IN_W +: IN_W] = lane_hit[gi] ? in_data_i : acc_q[gi*IN_W +: IN_W];
        assign merged_masked[gi*IN_W +: IN_W] = keep_mask[gi] ? merged[gi*IN_W +: IN_W]
                                                              : {IN_W{1'b0}};
    end

    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        full_d = full_q;
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;

        if (xfer) begin
            full_d = 1'b0;
        end

        // A completing accept overrides the clear above, giving a bubble-free reload.
        if (accept) begin
            if (complete) begin
                data_d = merged_masked;
                keep_d = keep_mask;
                last_d = in_last_i;
                full_d = 1'b1;
                idx_d  = '0;
                acc_d  = '0;
            end else begin
                acc_d = merged;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            idx_q  <= '0;
            acc_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else if (en_i) begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            full_q <= full_d;
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    assign out_data_o = data_q;
    assign out_keep_o = keep_q;
    assign out_last_o = last_q;

endmodule
